// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache-to-RAM write buffer.
package cache_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 4;

   // IDLE : nothing on the RAM bus
   // DRAIN: head entry presented as a RAM write until memDone
   // READ : buffered-miss read presented to RAM until memDone
   // RESP : one cycle returning the RAM read data to the cache
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } wb_state_t;

endpackage

// File: rtl/wb_entry_file.sv
// Circular store of posted writes. Entries are pushed at the tail and
// popped from the head. A combinational lookup returns the youngest
// valid entry whose address matches, so a read always sees the newest
// buffered value for that word.
module wb_entry_file
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int PTR_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] match_addr,
   output logic                  match_hit,
   output logic [DATA_WIDTH-1:0] match_data,
   output logic [ADDR_WIDTH-1:0] head_addr,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [PTR_W:0]        count
);

   logic [DEPTH-1:0]      entry_valid;
   logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
   logic [DATA_WIDTH-1:0] entry_data [DEPTH];
   logic [PTR_W-1:0]      head_ptr;
   logic [PTR_W-1:0]      tail_ptr;
   logic [PTR_W-1:0]      scan_idx;

   // Entry storage, pointers and occupancy; reset discards every entry.
   // Push and pop never target the same slot: push needs count<DEPTH and
   // pop needs count>0, so a shared slot would require both at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry_valid <= '0;
         head_ptr    <= '0;
         tail_ptr    <= '0;
         count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] <= '0;
            entry_data[i] <= '0;
         end
      end else begin
         if (push) begin
            entry_valid[tail_ptr] <= 1'b1;
            entry_addr[tail_ptr]  <= push_addr;
            entry_data[tail_ptr]  <= push_data;
            tail_ptr              <= tail_ptr + PTR_W'(1);
         end
         if (pop) begin
            entry_valid[head_ptr] <= 1'b0;
            head_ptr              <= head_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Age-ordered scan from oldest to youngest; a later match overrides an
   // earlier one so the youngest matching write supplies the data.
   always_comb begin
      match_hit  = 1'b0;
      match_data = '0;
      scan_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_ptr + PTR_W'(i);
         if (entry_valid[scan_idx] && (entry_addr[scan_idx] == match_addr)) begin
            match_hit  = 1'b1;
            match_data = entry_data[scan_idx];
         end
      end
   end

   assign head_addr = entry_addr[head_ptr];
   assign head_data = entry_data[head_ptr];

endmodule

// File: rtl/ram_write_buffer.sv
// Posted write buffer between the cache controller and main RAM.
// Writes complete to the cache one cycle after acceptance and drain to
// RAM strictly in order. Reads are served from the youngest matching
// buffered write; a miss stalls the cache, goes to RAM ahead of any
// drain that has not started yet, and completes in RESP.
//
// Handshakes: the cache side presents reqRead or reqWrite with reqAddr
// (and reqWriteData) and the request is taken on a rising edge where
// reqReady=1; reqDone pulses exactly once per accepted request. The RAM
// side holds memRead or memWrite with stable memAddr/memWriteData until
// the single-cycle memDone, which is ignored unless an access is open.
module ram_write_buffer
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int PTR_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reqRead,
   input  logic                  reqWrite,
   input  logic [ADDR_WIDTH-1:0] reqAddr,
   input  logic [DATA_WIDTH-1:0] reqWriteData,
   output logic [DATA_WIDTH-1:0] reqReadData,
   output logic                  reqDone,
   output logic                  reqReady,
   output logic                  memRead,
   output logic                  memWrite,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memWriteData,
   input  logic [DATA_WIDTH-1:0] memReadData,
   input  logic                  memDone,
   output logic                  empty,
   output wb_state_t             dbg_state
);

   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   wb_state_t             state;
   wb_state_t             next_state;
   logic                  rd_pending;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] read_data_q;
   logic                  done_q;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  rd_hit_acc;
   logic                  rd_miss_acc;
   logic                  pop;
   logic                  match_hit;
   logic [DATA_WIDTH-1:0] match_data;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;
   logic [PTR_W:0]        count;

   // A read miss blocks everything until its data returns; a full buffer
   // blocks new requests while draining carries on.
   assign reqReady    = rst & (count < CNT_FULL) & ~rd_pending;
   assign wr_acc      = reqReady & reqWrite;
   assign rd_acc      = reqReady & reqRead & ~reqWrite;
   assign rd_hit_acc  = rd_acc & match_hit;
   assign rd_miss_acc = rd_acc & ~match_hit;
   assign pop         = (state == DRAIN) & memDone;

   assign empty       = (count == '0) & (state == IDLE) & ~rd_pending;
   assign reqReadData = read_data_q;
   assign dbg_state   = state;

   wb_entry_file #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) u_entry_file (
      .clk        (clk),
      .rst        (rst),
      .push       (wr_acc),
      .push_addr  (reqAddr),
      .push_data  (reqWriteData),
      .pop        (pop),
      .match_addr (reqAddr),
      .match_hit  (match_hit),
      .match_data (match_data),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (count)
   );

   // State register; reset drops any open RAM access immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and RAM/cache-side strobes. A miss (pending, or being
   // accepted this cycle) wins over any drain not yet on the bus, but an
   // open RAM write always runs to its memDone.
   always_comb begin
      next_state   = state;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      memAddr      = '0;
      memWriteData = '0;
      reqDone      = done_q;
      case (state)
         IDLE: begin
            if (rd_pending || rd_miss_acc) begin
               next_state = READ;
            end else if (count != '0) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            memWrite     = 1'b1;
            memAddr      = head_addr;
            memWriteData = head_data;
            if (memDone) begin
               if (rd_pending || rd_miss_acc) begin
                  next_state = READ;
               end else if ((count > CNT_ONE) || wr_acc) begin
                  next_state = DRAIN;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         READ: begin
            memRead = 1'b1;
            memAddr = rd_addr;
            if (memDone) begin
               next_state = RESP;
            end
         end
         RESP: begin
            reqDone    = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Request bookkeeping: one-cycle completion for writes and read hits,
   // miss address capture, and the read data register that holds its
   // value until the next read completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q      <= 1'b0;
         rd_pending  <= 1'b0;
         rd_addr     <= '0;
         read_data_q <= '0;
      end else begin
         done_q <= wr_acc | rd_hit_acc;
         if (rd_hit_acc) begin
            read_data_q <= match_data;
         end
         if (rd_miss_acc) begin
            rd_pending <= 1'b1;
            rd_addr    <= reqAddr;
         end
         if ((state == READ) && memDone) begin
            read_data_q <= memReadData;
         end
         if (state == RESP) begin
            rd_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_write_buffer.sv
// Bench for ram_write_buffer: a RAM model with programmable latency, a
// coherent-memory reference (every read returns the last value written
// to that address) and an in-order queue of expected RAM writes.
`timescale 1ns/1ps
module tb_ram_write_buffer;
   import cache_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT ----------------
   logic          reqRead = 1'b0;
   logic          reqWrite = 1'b0;
   logic [AW-1:0] reqAddr = '0;
   logic [DW-1:0] reqWriteData = '0;
   logic [DW-1:0] reqReadData;
   logic          reqDone;
   logic          reqReady;
   logic          memRead;
   logic          memWrite;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWriteData;
   logic [DW-1:0] memReadData = '0;
   logic          memDone;
   logic          empty;
   wb_state_t     dbg_state;

   logic ram_done = 1'b0;
   logic spur_done = 1'b0;
   assign memDone = ram_done | spur_done;

   ram_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .PTR_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .reqRead      (reqRead),
      .reqWrite     (reqWrite),
      .reqAddr      (reqAddr),
      .reqWriteData (reqWriteData),
      .reqReadData  (reqReadData),
      .reqDone      (reqDone),
      .reqReady     (reqReady),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .memAddr      (memAddr),
      .memWriteData (memWriteData),
      .memReadData  (memReadData),
      .memDone      (memDone),
      .empty        (empty),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard / reference ----------------
   logic [DW-1:0]    ram_mem [0:65535];
   logic [DW-1:0]    ref_mem [0:65535];
   logic [AW+DW-1:0] exp_q[$];
   logic [AW:0]      op_q[$];
   int               touched[$];
   int n_total = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- RAM model ----------------
   int ram_lat = 3;
   bit ram_stall = 1'b0;
   int lat_cnt = 0;
   int done_mark = -1;
   int rd_cycles = 0;

   always @(negedge clk) begin
      logic [AW+DW-1:0] exp_ent;
      if (memRead) rd_cycles++;
      if (!rst) begin
         ram_done = 1'b0;
         lat_cnt = 0;
      end else if (ram_done) begin
         ram_done = 1'b0;
         lat_cnt = 0;
      end else if (!(memRead || memWrite)) begin
         lat_cnt = 0;
      end else if (!ram_stall) begin
         lat_cnt++;
         if (lat_cnt >= ram_lat) begin
            ram_done = 1'b1;
            if (done_mark < 0) done_mark = cyc;
            if (memWrite) begin
               op_q.push_back({1'b0, memAddr});
               exp_ent = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
               check("wr_order", {memAddr, memWriteData}, exp_ent);
               ram_mem[memAddr] = memWriteData;
            end else begin
               op_q.push_back({1'b1, memAddr});
               memReadData = ram_mem[memAddr];
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (reqReady) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ready_timeout", reqReady, 1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc_cyc);
      bit ok;
      acc_cyc = -1;
      wait_ready(ok);
      if (ok) begin
         reqWrite = 1'b1;
         reqAddr = a;
         reqWriteData = d;
         acc_cyc = cyc;
         @(posedge clk);
         exp_q.push_back({a, d});
         ref_mem[a] = d;
         touched.push_back(int'(a));
         #1;
         check("wr_done", reqDone, 1);
         reqWrite = 1'b0;
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input string tag, output int lat);
      bit ok;
      logic [DW-1:0] exp;
      lat = -1;
      wait_ready(ok);
      if (ok) begin
         reqRead = 1'b1;
         reqAddr = a;
         exp = ref_mem[a];
         @(posedge clk);
         #1;
         reqRead = 1'b0;
         for (int n = 1; n <= 300; n++) begin
            if (reqDone) begin
               lat = n;
               break;
            end
            @(posedge clk);
            #1;
         end
         if (lat > 0) check(tag, reqReadData, exp);
         else check({tag, "_timeout"}, reqDone, 1);
      end
   endtask

   task automatic wait_empty(input string tag);
      for (int n = 0; n < 1000 && !empty; n++) @(negedge clk);
      check(tag, empty, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      int lat;
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int lat;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [AW-1:0] t6_addr [9];

      for (int i = 0; i < 65536; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end

      // Reset values
      #12;
      check("rst_ready", reqReady, 0);
      check("rst_empty", empty, 1);
      check("rst_memwrite", memWrite, 0);
      check("rst_memread", memRead, 0);
      check("rst_done", reqDone, 0);
      check("rst_rdata", reqReadData, 0);
      check("rst_memaddr", memAddr, 0);
      check("rst_memwdata", memWriteData, 0);
      check("rst_state", dbg_state, IDLE);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rel_ready", reqReady, 1);

      // 1: three writes drained in order
      ram_lat = 3;
      do_write(16'h0010, 32'hCAFE_BABE, acc);
      do_write(16'h0020, 32'hAAAA_5555, acc);
      do_write(16'h0300, 32'hC4EC_0001, acc);
      wait_empty("t1_empty");
      check("t1_q_drained", exp_q.size(), 0);
      check("t1_ram_10", ram_mem[16'h0010], 32'hCAFE_BABE);
      check("t1_ram_20", ram_mem[16'h0020], 32'hAAAA_5555);
      check("t1_ram_300", ram_mem[16'h0300], 32'hC4EC_0001);

      // memDone while idle must be ignored
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      check("spur_state", dbg_state, IDLE);
      check("spur_empty", empty, 1);
      check("spur_memwrite", memWrite, 0);

      // 2: RAM stalled, fifth write waits for the first memDone
      ram_stall = 1'b1;
      for (int i = 0; i < 4; i++) do_write(16'h0200 + 16'(i), $urandom, acc);
      check("t2_full", reqReady, 0);
      done_mark = -1;
      ram_stall = 1'b0;
      do_write(16'h0204, $urandom, acc);
      check("t2_5th_cycle", acc, done_mark + 1);
      wait_empty("t2_empty");

      // 3: duplicate addresses, read served from the youngest entry
      rd_cycles = 0;
      ram_stall = 1'b1;
      do_write(16'h0100, 32'h9999_8888, acc);
      do_write(16'h0100, 32'h1234_5678, acc);
      do_read(16'h0100, "t3_rdata", lat);
      check("t3_hit_lat", lat, 1);
      ram_stall = 1'b0;
      wait_empty("t3_empty");
      check("t3_no_memread", rd_cycles, 0);
      check("t3_ram_100", ram_mem[16'h0100], 32'h1234_5678);

      // 4: read miss overtakes queued (not started) drains
      ram_mem[16'h0043] = 32'hB0B0_B0B0;
      ref_mem[16'h0043] = 32'hB0B0_B0B0;
      ram_lat = 3;
      op_q.delete();
      do_write(16'h0050, 32'h5050_0001, acc);
      do_write(16'h0051, 32'h5151_0002, acc);
      do_write(16'h0052, 32'h5252_0003, acc);
      do_read(16'h0043, "t4_rdata", lat);
      wait_empty("t4_empty");
      check("t4_ops", op_q.size(), 4);
      if (op_q.size() == 4) begin
         check("t4_op0", op_q[0], {1'b0, 16'h0050});
         check("t4_op1", op_q[1], {1'b1, 16'h0043});
         check("t4_op2", op_q[2], {1'b0, 16'h0051});
         check("t4_op3", op_q[3], {1'b0, 16'h0052});
      end

      // 5: reset in the middle of a RAM write
      ram_stall = 1'b1;
      do_write(16'h0500, $urandom, acc);
      do_write(16'h0501, $urandom, acc);
      do_write(16'h0502, $urandom, acc);
      for (int n = 0; n < 50 && !memWrite; n++) @(negedge clk);
      check("t5_memwrite_pre", memWrite, 1);
      rst = 1'b0;
      #1;
      check("t5_memwrite_rst", memWrite, 0);
      check("t5_empty_rst", empty, 1);
      check("t5_ready_rst", reqReady, 0);
      foreach (exp_q[i]) ref_mem[exp_q[i][AW+DW-1:DW]] = ram_mem[exp_q[i][AW+DW-1:DW]];
      exp_q.delete();
      ram_stall = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_ready_rel", reqReady, 1);
      check("t5_empty_rel", empty, 1);

      // 6: nine writes through four entries, including the top address
      for (int i = 0; i < 9; i++) begin
         t6_addr[i] = (i == 5) ? 16'hFFFF : 16'($urandom_range(16'h0600, 16'h06FF));
         d = (i == 5) ? 32'hFFFF_FFFF : $urandom;
         ram_lat = $urandom_range(1, 4);
         do_write(t6_addr[i], d, acc);
      end
      wait_empty("t6_empty");
      for (int i = 0; i < 9; i++) check("t6_ram", ram_mem[t6_addr[i]], ref_mem[t6_addr[i]]);
      check("t6_ram_ffff", ram_mem[16'hFFFF], 32'hFFFF_FFFF);

      // Random mix on a small address window to exercise hits and misses
      for (int i = 0; i < 60; i++) begin
         ram_lat = $urandom_range(1, 5);
         a = 16'h0700 + 16'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, $urandom, acc);
         end else begin
            do_read(a, "rnd_rdata", lat);
         end
      end
      wait_empty("rnd_empty");
      check("rnd_q_drained", exp_q.size(), 0);
      foreach (touched[i]) check("final_ram", ram_mem[touched[i]], ref_mem[touched[i]]);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
